// File: rtl/spi_sdcmd_seq.sv
//==============================================================================
// Module      : spi_sdcmd_seq
// Description : Runs one SD-card SPI-mode command through the apb_spi
//               controller, acting as its APB master: loads the 5 command
//               bytes, starts the transfer with CRC7, drops the echo bytes,
//               polls for the response token and collects R1/R3/R7 bytes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package spi_sdcmd_pkg;
    typedef struct packed {
        logic        pselx;
        logic        penable;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
    } apb_in_type;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_out_type;
endpackage

module spi_sdcmd_seq
    import spi_sdcmd_pkg::*;
#(
    parameter logic        ASYNC_RESET = 1'b1,
    parameter logic [31:0] SPI_BASE    = 32'h0,
    parameter int          NCR_MAX     = 16
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    output apb_in_type  o_apbi,
    input  apb_out_type i_apbo,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [5:0]  i_req_cmd,
    input  logic [31:0] i_req_arg,
    input  logic [2:0]  i_req_resp_bytes,
    output logic        o_resp_valid,
    output logic [39:0] o_resp_data,
    output logic        o_resp_timeout,
    output logic        o_resp_err
);

    localparam logic [31:0] c_OFF_CTRL  = 32'h44;
    localparam logic [31:0] c_OFF_TX    = 32'h48;
    localparam logic [31:0] c_OFF_RX    = 32'h4C;
    localparam logic [7:0]  c_NCR_MAX   = 8'(NCR_MAX);

    typedef enum logic [3:0] {
        ST_IDLE, ST_TXB, ST_CTRL_CMD, ST_DISCARD, ST_CTRL_POLL,
        ST_RD_POLL, ST_CTRL_TAIL, ST_RD_TAIL, ST_DONE
    } state_t;

    typedef enum logic [1:0] {AP_IDLE, AP_SETUP, AP_ACCESS} ap_state_t;

    state_t      r_state, w_state_nx;
    ap_state_t   r_ap, w_ap_nx;
    logic [2:0]  r_k, w_k_nx, r_d, w_d_nx, r_n, w_n_nx, r_rb;
    logic [7:0]  r_p, w_p_nx;
    logic [5:0]  r_cmd;
    logic [31:0] r_arg;
    logic [39:0] r_resp_data, w_resp_nx;
    logic        r_timeout, w_to_nx, r_err, w_err_nx;
    logic [31:0] r_paddr, r_pwdata;
    logic        r_pwrite;
    logic [31:0] w_req_addr, w_req_data;
    logic        w_req_write, w_need;
    logic        w_rst_n, w_accept, w_ap_done, w_rx_empty;
    logic [7:0]  w_rx_byte, w_p_inc;
    logic [2:0]  w_k_inc, w_d_inc, w_n_dec, w_rb_clamp;
    logic        w_unused_prdata;

    // Only the asynchronous flop style is implemented; both branches route the pin.
    if (ASYNC_RESET) begin : g_rst_async
        assign w_rst_n = i_nrst;
    end else begin : g_rst_fallback
        assign w_rst_n = i_nrst;
    end

    assign w_accept        = i_req_valid && (r_state == ST_IDLE);
    assign w_ap_done       = (r_ap == AP_ACCESS) && i_apbo.pready;
    assign w_rx_empty      = i_apbo.prdata[31];
    assign w_rx_byte       = i_apbo.prdata[7:0];
    assign w_unused_prdata = ^i_apbo.prdata[30:8];
    assign w_k_inc         = (r_k == 3'd4)  ? r_k : r_k + 3'd1;
    assign w_d_inc         = (r_d == 3'd6)  ? r_d : r_d + 3'd1;
    assign w_n_dec         = (r_n == 3'd0)  ? r_n : r_n - 3'd1;
    assign w_p_inc         = (r_p == 8'hFF) ? r_p : r_p + 8'd1;
    assign w_rb_clamp      = (i_req_resp_bytes == 3'd0) ? 3'd1 :
                             (i_req_resp_bytes > 3'd5)  ? 3'd5 : i_req_resp_bytes;

    // Which APB access the current sequencer step needs
    always_comb begin
        w_need      = 1'b1;
        w_req_write = 1'b1;
        w_req_addr  = SPI_BASE + c_OFF_CTRL;
        w_req_data  = 32'h0;
        case (r_state)
            ST_TXB: begin
                w_req_addr = SPI_BASE + c_OFF_TX;
                case (r_k)
                    3'd0:    w_req_data = {24'h0, 2'b01, r_cmd};
                    3'd1:    w_req_data = {24'h0, r_arg[31:24]};
                    3'd2:    w_req_data = {24'h0, r_arg[23:16]};
                    3'd3:    w_req_data = {24'h0, r_arg[15:8]};
                    default: w_req_data = {24'h0, r_arg[7:0]};
                endcase
            end
            ST_CTRL_CMD:  w_req_data = 32'h0005_0080;
            ST_CTRL_POLL: w_req_data = 32'h0001_0000;
            ST_CTRL_TAIL: w_req_data = {13'b0, r_n, 16'h0};
            ST_DISCARD, ST_RD_POLL, ST_RD_TAIL: begin
                w_req_write = 1'b0;
                w_req_addr  = SPI_BASE + c_OFF_RX;
            end
            default: w_need = 1'b0;
        endcase
    end

    // APB sub-FSM next state: setup for one cycle, access until pready
    always_comb begin
        w_ap_nx = r_ap;
        case (r_ap)
            AP_IDLE:   if (w_need) w_ap_nx = AP_SETUP;
            AP_SETUP:  w_ap_nx = AP_ACCESS;
            AP_ACCESS: if (i_apbo.pready) w_ap_nx = AP_IDLE;
            default:   w_ap_nx = AP_IDLE;
        endcase
    end

    // APB sub-FSM register; request fields are frozen when an access starts
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ap     <= AP_IDLE;
            r_paddr  <= 32'h0;
            r_pwdata <= 32'h0;
            r_pwrite <= 1'b0;
        end else begin
            r_ap <= w_ap_nx;
            if (r_ap == AP_IDLE && w_need) begin
                r_paddr  <= w_req_addr;
                r_pwdata <= w_req_data;
                r_pwrite <= w_req_write;
            end
        end
    end

    // Sequencer next state and counter/response updates; steps only on access completion
    always_comb begin
        w_state_nx = r_state;
        w_k_nx     = r_k;
        w_d_nx     = r_d;
        w_p_nx     = r_p;
        w_n_nx     = r_n;
        w_resp_nx  = r_resp_data;
        w_to_nx    = r_timeout;
        w_err_nx   = r_err;
        if (r_state == ST_IDLE) begin
            if (w_accept) begin
                w_state_nx = ST_TXB;
                w_k_nx     = 3'd0;
                w_d_nx     = 3'd0;
                w_p_nx     = 8'd0;
                w_n_nx     = 3'd0;
                w_resp_nx  = 40'h0;
                w_to_nx    = 1'b0;
                w_err_nx   = 1'b0;
            end
        end else if (r_state == ST_DONE) begin
            w_state_nx = ST_IDLE;
        end else if (w_ap_done) begin
            if (i_apbo.pslverr) begin
                w_err_nx   = 1'b1;
                w_state_nx = ST_DONE;
            end else begin
                case (r_state)
                    ST_TXB: begin
                        if (r_k == 3'd4) w_state_nx = ST_CTRL_CMD;
                        else             w_k_nx     = w_k_inc;
                    end
                    ST_CTRL_CMD: begin
                        w_state_nx = ST_DISCARD;
                        w_d_nx     = 3'd0;
                    end
                    ST_DISCARD: if (!w_rx_empty) begin
                        w_d_nx = w_d_inc;
                        if (w_d_inc == 3'd6) begin
                            w_state_nx = ST_CTRL_POLL;
                            w_p_nx     = 8'd0;
                        end
                    end
                    ST_CTRL_POLL: w_state_nx = ST_RD_POLL;
                    ST_RD_POLL: if (!w_rx_empty) begin
                        if (w_rx_byte != 8'hFF) begin
                            w_resp_nx  = {r_resp_data[31:0], w_rx_byte};
                            w_n_nx     = r_rb - 3'd1;
                            w_state_nx = (r_rb == 3'd1) ? ST_DONE : ST_CTRL_TAIL;
                        end else begin
                            w_p_nx = w_p_inc;
                            if (w_p_inc == c_NCR_MAX) begin
                                w_to_nx    = 1'b1;
                                w_resp_nx  = 40'hFF;
                                w_state_nx = ST_DONE;
                            end else begin
                                w_state_nx = ST_CTRL_POLL;
                            end
                        end
                    end
                    ST_CTRL_TAIL: w_state_nx = ST_RD_TAIL;
                    ST_RD_TAIL: if (!w_rx_empty) begin
                        w_resp_nx = {r_resp_data[31:0], w_rx_byte};
                        w_n_nx    = w_n_dec;
                        if (w_n_dec == 3'd0) w_state_nx = ST_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sequencer state, counters and latched request
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_k         <= 3'd0;
            r_d         <= 3'd0;
            r_p         <= 8'd0;
            r_n         <= 3'd0;
            r_rb        <= 3'd1;
            r_cmd       <= 6'd0;
            r_arg       <= 32'h0;
            r_resp_data <= 40'h0;
            r_timeout   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_k         <= w_k_nx;
            r_d         <= w_d_nx;
            r_p         <= w_p_nx;
            r_n         <= w_n_nx;
            r_resp_data <= w_resp_nx;
            r_timeout   <= w_to_nx;
            r_err       <= w_err_nx;
            if (w_accept) begin
                r_cmd <= i_req_cmd;
                r_arg <= i_req_arg;
                r_rb  <= w_rb_clamp;
            end
        end
    end

    // Output drive: APB strobes decode straight from the sub-FSM state
    always_comb begin
        o_apbi         = '0;
        o_apbi.pselx   = (r_ap != AP_IDLE);
        o_apbi.penable = (r_ap == AP_ACCESS);
        o_apbi.paddr   = r_paddr;
        o_apbi.pwrite  = r_pwrite;
        o_apbi.pwdata  = r_pwdata;
        o_apbi.pstrb   = 4'hF;
        o_apbi.pprot   = 3'b000;
        o_req_ready    = (r_state == ST_IDLE);
        o_resp_valid   = (r_state == ST_DONE);
        o_resp_data    = r_resp_data;
        o_resp_timeout = r_timeout;
        o_resp_err     = r_err;
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_sdcmd_seq.sv
//==============================================================================
// Module      : tb_spi_sdcmd_seq
// Description : Directed bench for spi_sdcmd_seq with an APB apb_spi slave
//               model (write log, scripted Rx FIFO, error and stall hooks).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_sdcmd_seq;
    import spi_sdcmd_pkg::*;

    localparam logic [31:0] c_BASE   = 32'h1000_0000;
    localparam logic [31:0] c_A_CTRL = c_BASE + 32'h44;
    localparam logic [31:0] c_A_TX   = c_BASE + 32'h48;

    logic        clk = 1'b0;
    logic        nrst;
    apb_in_type  apbi;
    apb_out_type apbo;
    logic        req_valid, req_ready;
    logic [5:0]  req_cmd;
    logic [31:0] req_arg;
    logic [2:0]  req_rb;
    logic        resp_valid, resp_timeout, resp_err;
    logic [39:0] resp_data;

    always #5 clk = ~clk;

    spi_sdcmd_seq #(.ASYNC_RESET(1'b1), .SPI_BASE(c_BASE), .NCR_MAX(16)) dut (
        .i_clk(clk), .i_nrst(nrst), .o_apbi(apbi), .i_apbo(apbo),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_cmd(req_cmd),
        .i_req_arg(req_arg), .i_req_resp_bytes(req_rb), .o_resp_valid(resp_valid),
        .o_resp_data(resp_data), .o_resp_timeout(resp_timeout), .o_resp_err(resp_err)
    );

    // Slave model state: rx_mem bit 8 marks an "Rx FIFO empty" read
    logic [8:0]  rx_mem [0:127];
    int          rx_wp = 0, rx_rp = 0;
    logic [31:0] wl_addr [0:255];
    logic [31:0] wl_data [0:255];
    int          wl_rdc  [0:255];
    int          wr_cnt = 0, rd_cnt = 0, err_at = -1, cyc = 0, err_cyc = 0;
    int          resp_cnt = 0, resp_cyc = 0;
    logic        stall = 1'b0;
    int          n_checks = 0, n_fail = 0;

    always_comb begin
        apbo.pready  = ~stall;
        apbo.prdata  = 32'h0000_00FF;
        if (rx_rp < rx_wp) apbo.prdata = {rx_mem[rx_rp][8], 23'h0, rx_mem[rx_rp][7:0]};
        apbo.pslverr = apbi.pselx && apbi.penable && apbi.pwrite && (wr_cnt == err_at);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (apbi.pselx && apbi.penable && apbo.pready) begin
            if (apbi.pwrite) begin
                wl_addr[wr_cnt[7:0]] <= apbi.paddr;
                wl_data[wr_cnt[7:0]] <= apbi.pwdata;
                wl_rdc[wr_cnt[7:0]]  <= rd_cnt;
                if (apbo.pslverr) err_cyc <= cyc;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
                if (rx_rp < rx_wp) rx_rp <= rx_rp + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (resp_valid) begin
            resp_cnt <= resp_cnt + 1;
            resp_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        check_eq(tag, {wl_addr[idx[7:0]], wl_data[idx[7:0]]}, {a, d});
    endtask

    task automatic check_tx(input string tag, input int w0, input logic [39:0] bytes);
        for (int i = 0; i < 5; i++)
            check_wr($sformatf("%s_tx%0d", tag, i), w0 + i, c_A_TX, {24'h0, bytes[39-8*i -: 8]});
        check_wr({tag, "_ctrl_cmd"}, w0 + 5, c_A_CTRL, 32'h0005_0080);
    endtask

    task automatic push_rx(input logic [8:0] v);
        rx_mem[rx_wp] = v;
        rx_wp++;
    endtask

    task automatic push_echo();
        for (int i = 0; i < 6; i++) push_rx({1'b0, 8'h30 + 8'(i)});
    endtask

    task automatic send_cmd(input logic [5:0] c, input logic [31:0] a, input logic [2:0] rb);
        int g = 0;
        while (!req_ready && g < 100) begin @(negedge clk); g++; end
        if (!req_ready) check_eq("req_ready_wait", {63'h0, req_ready}, 64'h1);
        req_cmd = c; req_arg = a; req_rb = rb; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int c0);
        int g = 0;
        while (resp_cnt == c0 && g < 3000) begin @(negedge clk); g++; end
        repeat (3) @(negedge clk);
        check_eq({tag, "_pulses"}, 64'(resp_cnt - c0), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, c0, g, cnt;
        nrst = 1'b0; req_valid = 1'b0; req_cmd = '0; req_arg = '0; req_rb = 3'd1;
        #1;
        check_eq("rst_apb", {apbi.pselx, apbi.penable, apbi.paddr, apbi.pwdata}, 66'h0);
        check_eq("rst_ready", {63'h0, req_ready}, 64'h1);
        check_eq("rst_resp", {resp_valid, resp_timeout, resp_err, resp_data}, 43'h0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // CMD0: two filler bytes before the R1 token
        w0 = wr_cnt; c0 = resp_cnt;
        push_echo(); push_rx(9'h0FF); push_rx(9'h0FF); push_rx(9'h001);
        send_cmd(6'd0, 32'h0, 3'd1);
        wait_resp("t1", c0);
        check_eq("t1_nwr", 64'(wr_cnt - w0), 64'd9);
        check_tx("t1", w0, 40'h40_00_00_00_00);
        for (int i = 0; i < 3; i++) check_wr($sformatf("t1_poll%0d", i), w0 + 6 + i, c_A_CTRL, 32'h0001_0000);
        check_eq("t1_resp", {resp_timeout, resp_err, resp_data}, {2'b00, 40'h01});

        // CMD8: R7, five bytes
        w0 = wr_cnt; c0 = resp_cnt;
        push_echo(); push_rx(9'h001); push_rx(9'h000); push_rx(9'h000); push_rx(9'h001); push_rx(9'h0AA);
        send_cmd(6'd8, 32'h0000_01AA, 3'd5);
        wait_resp("t2", c0);
        check_eq("t2_nwr", 64'(wr_cnt - w0), 64'd8);
        check_tx("t2", w0, 40'h48_00_00_01_AA);
        check_wr("t2_poll", w0 + 6, c_A_CTRL, 32'h0001_0000);
        check_wr("t2_tail", w0 + 7, c_A_CTRL, 32'h0004_0000);
        check_eq("t2_resp", {resp_timeout, resp_err, resp_data}, {2'b00, 40'h01000001AA});

        // Timeout: Rx returns only 0xFF after the echoes
        w0 = wr_cnt; c0 = resp_cnt;
        push_echo();
        send_cmd(6'd55, 32'h0, 3'd1);
        wait_resp("t3", c0);
        cnt = 0;
        for (int i = w0 + 6; i < wr_cnt; i++)
            if (wl_addr[i[7:0]] == c_A_CTRL && wl_data[i[7:0]] == 32'h0001_0000) cnt++;
        check_eq("t3_npoll", 64'(cnt), 64'd16);
        check_eq("t3_nwr", 64'(wr_cnt - w0), 64'd22);
        check_eq("t3_resp", {resp_timeout, resp_err, resp_data}, {2'b10, 40'hFF});

        // pslverr on the third Tx FIFO write
        w0 = wr_cnt; r0 = rd_cnt; c0 = resp_cnt;
        err_at = wr_cnt + 2;
        send_cmd(6'd17, 32'h0000_0200, 3'd1);
        wait_resp("t4", c0);
        err_at = -1;
        check_eq("t4_flags", {62'h0, resp_err, resp_timeout}, 64'h2);
        check_eq("t4_nwr", 64'(wr_cnt - w0), 64'd3);
        check_eq("t4_nrd", 64'(rd_cnt - r0), 64'd0);
        cnt = 0;
        for (int i = w0; i < wr_cnt; i++) if (wl_addr[i[7:0]] == c_A_CTRL) cnt++;
        check_eq("t4_no_ctrl", 64'(cnt), 64'd0);
        check_eq("t4_latency_ok", {63'h0, (resp_cyc > err_cyc) && (resp_cyc - err_cyc <= 2)}, 64'h1);
        check_eq("t4_ready", {63'h0, req_ready}, 64'h1);

        // Three empty Rx reads during the discard phase
        w0 = wr_cnt; r0 = rd_cnt; c0 = resp_cnt;
        push_rx(9'h100); push_rx(9'h100); push_rx(9'h100);
        push_echo(); push_rx(9'h005);
        send_cmd(6'd1, 32'h4000_0000, 3'd1);
        wait_resp("t5", c0);
        check_eq("t5_rd_before_poll", 64'(wl_rdc[(w0 + 6) % 256] - r0), 64'd9);
        check_eq("t5_nrd", 64'(rd_cnt - r0), 64'd10);
        check_eq("t5_nwr", 64'(wr_cnt - w0), 64'd7);
        check_eq("t5_resp", {resp_timeout, resp_err, resp_data}, {2'b00, 40'h05});

        // Reset while a poll read is stalled
        w0 = wr_cnt; c0 = resp_cnt;
        push_echo();
        send_cmd(6'd13, 32'h0, 3'd1);
        g = 0;
        while (wr_cnt < w0 + 7 && g < 500) begin @(negedge clk); g++; end
        stall = 1'b1;
        g = 0;
        while (!apbi.penable && g < 20) begin @(negedge clk); g++; end
        check_eq("t6_stalled", {62'h0, apbi.pselx, apbi.penable}, 64'h3);
        #1 nrst = 1'b0;
        #1;
        check_eq("t6_async_drop", {62'h0, apbi.pselx, apbi.penable}, 64'h0);
        repeat (2) @(negedge clk);
        nrst = 1'b1; stall = 1'b0;
        #1;
        check_eq("t6_ready_rel", {63'h0, req_ready}, 64'h1);
        check_eq("t6_resp_clr", {resp_timeout, resp_err, resp_data}, 42'h0);
        @(negedge clk);
        check_eq("t6_ready_c1", {63'h0, req_ready}, 64'h1);
        check_eq("t6_no_pulse", 64'(resp_cnt - c0), 64'd0);

        // Command after reset, two-byte response
        w0 = wr_cnt; c0 = resp_cnt;
        push_echo(); push_rx(9'h003); push_rx(9'h07E);
        send_cmd(6'd17, 32'h1234_5678, 3'd2);
        wait_resp("t7", c0);
        check_tx("t7", w0, 40'h51_12_34_56_78);
        check_wr("t7_tail", w0 + 7, c_A_CTRL, 32'h0001_0000);
        check_eq("t7_resp", {resp_timeout, resp_err, resp_data}, {2'b00, 40'h037E});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
